// File: rtl/ko_pkg.sv
// ko_pkg -- shared types and constants for the knockout match sequencer.
//
// Contents:
//   state_t            sequencer state encoding (IDLE, SF1, SF2, FINAL, EXTRA, DONE)
//   MATCH_*            match_id encoding (SF1=0, SF2=1, FINAL=2, NONE=3)
//   TEAM_ONE/TEAM_TWO  result-bit encoding (0 = team one won, 1 = team two won)
//   next_match_state   state that follows the resolution of a given match
//   state_match        match_id shown for a given state (EXTRA handled by the caller)
package ko_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SF1   = 3'd1,
        ST_SF2   = 3'd2,
        ST_FINAL = 3'd3,
        ST_EXTRA = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [1:0] MATCH_SF1   = 2'd0;
    localparam logic [1:0] MATCH_SF2   = 2'd1;
    localparam logic [1:0] MATCH_FINAL = 2'd2;
    localparam logic [1:0] MATCH_NONE  = 2'd3;

    localparam logic TEAM_ONE = 1'b0;
    localparam logic TEAM_TWO = 1'b1;

    function automatic state_t next_match_state(input logic [1:0] match);
        case (match)
            MATCH_SF1: return ST_SF2;
            MATCH_SF2: return ST_FINAL;
            default:   return ST_DONE;
        endcase
    endfunction

    function automatic logic [1:0] state_match(input state_t st);
        case (st)
            ST_SF1:   return MATCH_SF1;
            ST_SF2:   return MATCH_SF2;
            ST_FINAL: return MATCH_FINAL;
            default:  return MATCH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ko_score_keeper.sv
// ko_score_keeper -- the two saturating per-match goal counters.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   i_clear                    zero both counters (wins over increment)
//   i_inc_en                   goal pulses are counted only while high
//   i_goal_one, i_goal_two     one-cycle goal strobes
//   o_score_one, o_score_two   registered scores
//   o_one_ahead, o_two_ahead,
//   o_tied                     comparison of the scores *including* any goal
//                              arriving this cycle, so a goal coincident with
//                              match_end is counted before the decision
module ko_score_keeper #(
    parameter int SCORE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_inc_en,
    input  logic               i_goal_one,
    input  logic               i_goal_two,
    output logic [SCORE_W-1:0] o_score_one,
    output logic [SCORE_W-1:0] o_score_two,
    output logic               o_one_ahead,
    output logic               o_two_ahead,
    output logic               o_tied
);

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic [SCORE_W-1:0] r_one;
    logic [SCORE_W-1:0] r_two;
    logic [SCORE_W-1:0] w_one_next;
    logic [SCORE_W-1:0] w_two_next;

    // Saturating increment: a counter at its maximum simply holds.
    assign w_one_next = (i_inc_en && i_goal_one && (r_one != SCORE_MAX))
                        ? r_one + SCORE_W'(1) : r_one;
    assign w_two_next = (i_inc_en && i_goal_two && (r_two != SCORE_MAX))
                        ? r_two + SCORE_W'(1) : r_two;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_one <= '0;
            r_two <= '0;
        end else begin
            r_one <= w_one_next;
            r_two <= w_two_next;
        end
    end

    assign o_score_one = r_one;
    assign o_score_two = r_two;
    assign o_one_ahead = (w_one_next > w_two_next);
    assign o_two_ahead = (w_two_next > w_one_next);
    assign o_tied      = (w_one_next == w_two_next);

endmodule

// File: rtl/ko_match_sequencer.sv
// ko_match_sequencer -- runs SF1 (a vs b), SF2 (c vs d) and the FINAL in
// order, counts goals per match and latches the three winner-select bits.
//
// Optional feature macro: KO_EXTRA_TIME_EN. When defined, a tie at match_end
// enters EXTRA (scores kept, counting continues) and the interrupted match
// is held in a return register; when undefined, a tie resolves at once to
// team one and in_extra is tied low.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   start                       begin a tournament (accepted in IDLE/DONE only)
//   goal_one, goal_two          goal strobes for the current match
//   match_end                   end of regulation (or of extra time in EXTRA)
//   s0, s1, s2                  SF1 / SF2 / FINAL results (0 = team one)
//   match_id                    0 SF1, 1 SF2, 2 FINAL, 3 none
//   score_one, score_two        running scores
//   in_extra, busy, done        status
//
// Handshake: every input is a single-cycle strobe sampled on the rising
// clock edge; there is no ready/backpressure. Each decision is visible on
// the outputs exactly one cycle after the strobe that caused it.
module ko_match_sequencer
    import ko_pkg::*;
#(
    parameter int SCORE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               goal_one,
    input  logic               goal_two,
    input  logic               match_end,
    output logic               s0,
    output logic               s1,
    output logic               s2,
    output logic [1:0]         match_id,
    output logic [SCORE_W-1:0] score_one,
    output logic [SCORE_W-1:0] score_two,
    output logic               in_extra,
    output logic               busy,
    output logic               done
);

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_res;
    logic [2:0] w_res_next;
    logic       w_clear;
    logic       w_inc_en;
    logic       w_resolve;
    logic [1:0] w_cur_match;
    logic       w_one_ahead;
    logic       w_two_ahead;
    logic       w_tied;
    logic       w_bit;
`ifdef KO_EXTRA_TIME_EN
    logic [1:0] r_ret;
    logic [1:0] w_ret_next;
`endif

    // Goals count in every match state, including extra time.
    assign w_inc_en = (r_state == ST_SF1) || (r_state == ST_SF2) ||
                      (r_state == ST_FINAL) || (r_state == ST_EXTRA);

    // A tie always goes to team one (only reached on a tie in the default
    // build or at the end of extra time).
    assign w_bit = (w_tied || w_one_ahead) ? TEAM_ONE :
                   (w_two_ahead ? TEAM_TWO : TEAM_ONE);

    ko_score_keeper #(.SCORE_W(SCORE_W)) u_score (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_clear),
        .i_inc_en    (w_inc_en),
        .i_goal_one  (goal_one),
        .i_goal_two  (goal_two),
        .o_score_one (score_one),
        .o_score_two (score_two),
        .o_one_ahead (w_one_ahead),
        .o_two_ahead (w_two_ahead),
        .o_tied      (w_tied)
    );

    always_comb begin
        w_state_next = r_state;
        w_res_next   = r_res;
        w_clear      = 1'b0;
        w_resolve    = 1'b0;
        w_cur_match  = state_match(r_state);
`ifdef KO_EXTRA_TIME_EN
        w_ret_next   = r_ret;
`endif
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_next = ST_SF1;
                    w_clear      = 1'b1;
                    w_res_next   = '0;
                end
            end
            ST_SF1, ST_SF2, ST_FINAL: begin
                if (match_end) begin
`ifdef KO_EXTRA_TIME_EN
                    if (w_tied) begin
                        w_state_next = ST_EXTRA;
                        w_ret_next   = w_cur_match;
                    end else begin
                        w_resolve = 1'b1;
                    end
`else
                    w_resolve = 1'b1;
`endif
                end
            end
`ifdef KO_EXTRA_TIME_EN
            ST_EXTRA: begin
                w_cur_match = r_ret;
                if (match_end) begin
                    w_resolve = 1'b1;
                end
            end
`endif
            default: w_state_next = ST_IDLE;
        endcase

        if (w_resolve) begin
            w_clear      = 1'b1;
            w_state_next = next_match_state(w_cur_match);
            case (w_cur_match)
                MATCH_SF1:   w_res_next[0] = w_bit;
                MATCH_SF2:   w_res_next[1] = w_bit;
                MATCH_FINAL: w_res_next[2] = w_bit;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_res   <= '0;
`ifdef KO_EXTRA_TIME_EN
            r_ret   <= MATCH_SF1;
`endif
        end else begin
            r_state <= w_state_next;
            r_res   <= w_res_next;
`ifdef KO_EXTRA_TIME_EN
            r_ret   <= w_ret_next;
`endif
        end
    end

    assign s0   = r_res[0];
    assign s1   = r_res[1];
    assign s2   = r_res[2];
    assign busy = w_inc_en;
    assign done = (r_state == ST_DONE);
`ifdef KO_EXTRA_TIME_EN
    assign in_extra = (r_state == ST_EXTRA);
    assign match_id = (r_state == ST_EXTRA) ? r_ret : state_match(r_state);
`else
    assign in_extra = 1'b0;
    assign match_id = state_match(r_state);
`endif

endmodule

// File: tb/tb_ko_match_sequencer.sv
module tb_ko_match_sequencer;

  localparam int SW = 2;
  localparam int OW = 3 + 2 + 2 * SW + 3;

  // input vector {rst_n, start, goal_one, goal_two, match_end}
  localparam logic [4:0] IDL = 5'b10000;
  localparam logic [4:0] STA = 5'b11000;
  localparam logic [4:0] G1  = 5'b10100;
  localparam logic [4:0] G2  = 5'b10010;
  localparam logic [4:0] ME  = 5'b10001;
  localparam logic [4:0] RST = 5'b00000;

  logic clk;
  logic rst_n, start, goal_one, goal_two, match_end;
  logic s0, s1, s2, in_extra, busy, done;
  logic [1:0] match_id;
  logic [SW-1:0] score_one, score_two;
  logic [OW-1:0] obs;

  logic [OW-1:0] exp_q[$];
  int checks;
  int failures;

  ko_match_sequencer #(.SCORE_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .goal_one  (goal_one),
    .goal_two  (goal_two),
    .match_end (match_end),
    .s0        (s0),
    .s1        (s1),
    .s2        (s2),
    .match_id  (match_id),
    .score_one (score_one),
    .score_two (score_two),
    .in_extra  (in_extra),
    .busy      (busy),
    .done      (done)
  );

  assign obs = {s2, s1, s0, match_id, score_one, score_two, in_extra, busy, done};

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // expected observation: s = {s2,s1,s0}
  function automatic logic [OW-1:0] mk(input logic [2:0] s, input logic [1:0] mid,
                                       input int so, input int st,
                                       input logic ie, input logic b, input logic d);
    mk = {s, mid, so[SW-1:0], st[SW-1:0], ie, b, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [4:0] in, input logic [OW-1:0] e);
    exp_q.push_back(e);
    @(negedge clk);
    {rst_n, start, goal_one, goal_two, match_end} = in;
    @(posedge clk);
    #1;
    {rst_n, start, goal_one, goal_two, match_end} = IDL;
  endtask

  task automatic do_reset();
    @(negedge clk);
    {rst_n, start, goal_one, goal_two, match_end} = RST;
    repeat (2) @(posedge clk);
    #1;
    {rst_n, start, goal_one, goal_two, match_end} = IDL;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [4:0] ins[$];
    logic [OW-1:0] exps[$];
    logic [OW-1:0] e;
    ins  = '{RST, G1, G2 | ME};
    exps = '{mk(3'b000, 2'd3, 0, 0, 0, 0, 0),
             mk(3'b000, 2'd3, 0, 0, 0, 0, 0),
             mk(3'b000, 2'd3, 0, 0, 0, 0, 0)};
    for (int i = 0; i < ins.size(); i++) begin
      drive(ins[i], exps[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset step %0d: got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_tournament();
    logic [4:0] ins[$];
    logic [OW-1:0] exps[$];
    logic [OW-1:0] e;
    do_reset();
    ins  = '{STA, G1, G1, G2, ME, G2, G2, G2, ME, G1, ME, G1, STA};
    exps = '{mk(3'b000, 2'd0, 0, 0, 0, 1, 0),
             mk(3'b000, 2'd0, 1, 0, 0, 1, 0),
             mk(3'b000, 2'd0, 2, 0, 0, 1, 0),
             mk(3'b000, 2'd0, 2, 1, 0, 1, 0),
             mk(3'b000, 2'd1, 0, 0, 0, 1, 0),
             mk(3'b000, 2'd1, 0, 1, 0, 1, 0),
             mk(3'b000, 2'd1, 0, 2, 0, 1, 0),
             mk(3'b000, 2'd1, 0, 3, 0, 1, 0),
             mk(3'b010, 2'd2, 0, 0, 0, 1, 0),
             mk(3'b010, 2'd2, 1, 0, 0, 1, 0),
             mk(3'b010, 2'd3, 0, 0, 0, 0, 1),
             mk(3'b010, 2'd3, 0, 0, 0, 0, 1),
             mk(3'b000, 2'd0, 0, 0, 0, 1, 0)};
    for (int i = 0; i < ins.size(); i++) begin
      drive(ins[i], exps[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL tournament step %0d: got=%h exp=%h", i, obs, e);
      end
      repeat ($urandom_range(0, 2)) begin
        drive(IDL, exps[i]);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL tournament hold %0d: got=%h exp=%h", i, obs, e);
        end
      end
    end
  endtask

  task automatic test_extra_tie();
    logic [4:0] ins[$];
    logic [OW-1:0] exps[$];
    logic [OW-1:0] e;
    do_reset();
    ins = '{STA, G1, G2, ME, G2, ME};
`ifdef KO_EXTRA_TIME_EN
    exps = '{mk(3'b000, 2'd0, 0, 0, 0, 1, 0),
             mk(3'b000, 2'd0, 1, 0, 0, 1, 0),
             mk(3'b000, 2'd0, 1, 1, 0, 1, 0),
             mk(3'b000, 2'd0, 1, 1, 1, 1, 0),
             mk(3'b000, 2'd0, 1, 2, 1, 1, 0),
             mk(3'b001, 2'd1, 0, 0, 0, 1, 0)};
`else
    exps = '{mk(3'b000, 2'd0, 0, 0, 0, 1, 0),
             mk(3'b000, 2'd0, 1, 0, 0, 1, 0),
             mk(3'b000, 2'd0, 1, 1, 0, 1, 0),
             mk(3'b000, 2'd1, 0, 0, 0, 1, 0),
             mk(3'b000, 2'd1, 0, 1, 0, 1, 0),
             mk(3'b010, 2'd2, 0, 0, 0, 1, 0)};
`endif
    for (int i = 0; i < ins.size(); i++) begin
      drive(ins[i], exps[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL extra_tie step %0d: got=%h exp=%h", i, obs, e);
      end
      repeat ($urandom_range(0, 2)) begin
        drive(IDL, exps[i]);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL extra_tie hold %0d: got=%h exp=%h", i, obs, e);
        end
      end
    end
  endtask

  task automatic test_extra_still_tied();
    logic [4:0] ins[$];
    logic [OW-1:0] exps[$];
    logic [OW-1:0] e;
    do_reset();
    ins = '{STA, G1, G2, ME, G1, G2, ME, G1};
`ifdef KO_EXTRA_TIME_EN
    exps = '{mk(3'b000, 2'd0, 0, 0, 0, 1, 0),
             mk(3'b000, 2'd0, 1, 0, 0, 1, 0),
             mk(3'b000, 2'd0, 1, 1, 0, 1, 0),
             mk(3'b000, 2'd0, 1, 1, 1, 1, 0),
             mk(3'b000, 2'd0, 2, 1, 1, 1, 0),
             mk(3'b000, 2'd0, 2, 2, 1, 1, 0),
             mk(3'b000, 2'd1, 0, 0, 0, 1, 0),
             mk(3'b000, 2'd1, 1, 0, 0, 1, 0)};
`else
    exps = '{mk(3'b000, 2'd0, 0, 0, 0, 1, 0),
             mk(3'b000, 2'd0, 1, 0, 0, 1, 0),
             mk(3'b000, 2'd0, 1, 1, 0, 1, 0),
             mk(3'b000, 2'd1, 0, 0, 0, 1, 0),
             mk(3'b000, 2'd1, 1, 0, 0, 1, 0),
             mk(3'b000, 2'd1, 1, 1, 0, 1, 0),
             mk(3'b000, 2'd2, 0, 0, 0, 1, 0),
             mk(3'b000, 2'd2, 1, 0, 0, 1, 0)};
`endif
    for (int i = 0; i < ins.size(); i++) begin
      drive(ins[i], exps[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL still_tied step %0d: got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_saturation_coincident();
    logic [4:0] ins[$];
    logic [OW-1:0] exps[$];
    logic [OW-1:0] e;
    do_reset();
    ins  = '{STA, G1, G1, G1, G1, G1, G2, G1 | G2 | ME, G1, G2, G2 | ME};
    exps = '{mk(3'b000, 2'd0, 0, 0, 0, 1, 0),
             mk(3'b000, 2'd0, 1, 0, 0, 1, 0),
             mk(3'b000, 2'd0, 2, 0, 0, 1, 0),
             mk(3'b000, 2'd0, 3, 0, 0, 1, 0),
             mk(3'b000, 2'd0, 3, 0, 0, 1, 0),
             mk(3'b000, 2'd0, 3, 0, 0, 1, 0),
             mk(3'b000, 2'd0, 3, 1, 0, 1, 0),
             mk(3'b000, 2'd1, 0, 0, 0, 1, 0),
             mk(3'b000, 2'd1, 1, 0, 0, 1, 0),
             mk(3'b000, 2'd1, 1, 1, 0, 1, 0),
             mk(3'b010, 2'd2, 0, 0, 0, 1, 0)};
    for (int i = 0; i < ins.size(); i++) begin
      drive(ins[i], exps[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL saturation step %0d: got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid_match();
    logic [4:0] ins[$];
    logic [OW-1:0] exps[$];
    logic [OW-1:0] e;
    do_reset();
    ins  = '{STA, G2, ME, G1, G1, G2, RST | 5'b00100, G1, STA};
    exps = '{mk(3'b000, 2'd0, 0, 0, 0, 1, 0),
             mk(3'b000, 2'd0, 0, 1, 0, 1, 0),
             mk(3'b001, 2'd1, 0, 0, 0, 1, 0),
             mk(3'b001, 2'd1, 1, 0, 0, 1, 0),
             mk(3'b001, 2'd1, 2, 0, 0, 1, 0),
             mk(3'b001, 2'd1, 2, 1, 0, 1, 0),
             mk(3'b000, 2'd3, 0, 0, 0, 0, 0),
             mk(3'b000, 2'd3, 0, 0, 0, 0, 0),
             mk(3'b000, 2'd0, 0, 0, 0, 1, 0)};
    for (int i = 0; i < ins.size(); i++) begin
      drive(ins[i], exps[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_mid step %0d: got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_start_busy();
    logic [4:0] ins[$];
    logic [OW-1:0] exps[$];
    logic [OW-1:0] e;
    do_reset();
    ins  = '{STA, G1, STA, STA | G2, G1 | ME, STA};
    exps = '{mk(3'b000, 2'd0, 0, 0, 0, 1, 0),
             mk(3'b000, 2'd0, 1, 0, 0, 1, 0),
             mk(3'b000, 2'd0, 1, 0, 0, 1, 0),
             mk(3'b000, 2'd0, 1, 1, 0, 1, 0),
             mk(3'b000, 2'd1, 0, 0, 0, 1, 0),
             mk(3'b000, 2'd1, 0, 0, 0, 1, 0)};
    for (int i = 0; i < ins.size(); i++) begin
      drive(ins[i], exps[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL start_busy step %0d: got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    {rst_n, start, goal_one, goal_two, match_end} = RST;
    test_reset();
    test_tournament();
    test_extra_tie();
    test_extra_still_tied();
    test_saturation_coincident();
    test_reset_mid_match();
    test_start_busy();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
